// File: rtl/vocab_writer.sv
// Serialises packed vocabulary words into consecutive SRAM bytes and appends a 0x00 terminator.
// Optional per-byte readback verification is enabled by defining VOCAB_WRITER_READBACK_EN.
module vocab_writer #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WORD_LENGTH = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic [ADDR_WIDTH-1:0]             start_addr,
  input  logic [ADDR_WIDTH-1:0]             end_addr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0] in_word,
  input  logic                              in_last,
  output logic                              sram_cs,
  output logic                              sram_we,
  output logic [ADDR_WIDTH-1:0]             sram_addr,
  output logic [DATA_WIDTH-1:0]             sram_din,
  input  logic [DATA_WIDTH-1:0]             sram_dout,
  output logic                              busy,
  output logic                              done,
  output logic                              full,
  output logic                              error
);

  localparam int KW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORD_LENGTH - 1);

`ifdef VOCAB_WRITER_READBACK_EN
  typedef enum logic [2:0] {IDLE, WRITE, TERM, DONE, READ, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, TERM, DONE} state_t;
`endif

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]           end_q, end_d;
  logic [KW-1:0]                   k_q, k_d;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q, word_d;
  logic                            last_q, last_d;
  logic                            term_q, term_d;
  logic                            first_q, first_d;
  logic                            cs_q, cs_d;
  logic                            we_q, we_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           din_q, din_d;
  logic                            done_q, done_d;
  logic                            full_q, full_d;
  logic                            error_q, error_d;
  logic                            step_done;
  logic [ADDR_WIDTH-1:0]           base_addr;

  function automatic logic [DATA_WIDTH-1:0] char_at(
    input logic [WORD_LENGTH*DATA_WIDTH-1:0] w,
    input logic [KW-1:0]                     k
  );
    char_at = '0;
    for (int unsigned i = 0; i < WORD_LENGTH; i++) begin
      if (k == KW'(i)) char_at = w[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endfunction

`ifdef VOCAB_WRITER_READBACK_EN
  assign step_done = (state_q == CHECK);
`else
  logic unused_dout;
  assign unused_dout = ^sram_dout;
  assign step_done   = (state_q == WRITE) || (state_q == TERM);
`endif

  assign base_addr = first_q ? start_addr : ptr_q;

  // Outputs for the next cycle are computed here and registered, so the SRAM bus
  // reflects the state it is in rather than lagging it by a cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    k_d     = k_q;
    word_d  = word_q;
    last_d  = last_q;
    term_d  = term_q;
    first_d = first_q;
    cs_d    = cs_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = done_q;
    full_d  = full_q;
    error_d = error_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          word_d  = in_word;
          last_d  = in_last;
          first_d = 1'b0;
          if (first_q) end_d = end_addr;
          if (first_q && (end_addr < start_addr)) begin
            state_d = DONE;
            done_d  = 1'b1;
            full_d  = 1'b1;
          end else begin
            state_d = WRITE;
            k_d     = '0;
            term_d  = 1'b0;
            ptr_d   = base_addr;
            cs_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = base_addr;
            din_d   = in_word[DATA_WIDTH-1:0];
          end
        end
      end
`ifdef VOCAB_WRITER_READBACK_EN
      WRITE, TERM: begin
        state_d = READ;
        we_d    = 1'b0;
      end
      READ: begin
        state_d = CHECK;
        cs_d    = 1'b0;
      end
      CHECK: begin
        if (sram_dout != din_q) error_d = 1'b1;
      end
`endif
      default: ;
    endcase

    // A byte (or terminator) has completed: pick the next write or stop.
    if (step_done) begin
      cs_d = 1'b0;
      we_d = 1'b0;
      if (term_q) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else if (ptr_q == end_q) begin
        state_d = DONE;
        done_d  = 1'b1;
        full_d  = 1'b1;
      end else if (k_q != K_LAST) begin
        state_d = WRITE;
        k_d     = k_q + KW'(1);
        ptr_d   = ptr_q + ADDR_WIDTH'(1);
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ptr_q + ADDR_WIDTH'(1);
        din_d   = char_at(word_q, k_q + KW'(1));
      end else if (last_q) begin
        state_d = TERM;
        term_d  = 1'b1;
        ptr_d   = ptr_q + ADDR_WIDTH'(1);
        cs_d    = 1'b1;
        we_d    = 1'b1;
        addr_d  = ptr_q + ADDR_WIDTH'(1);
        din_d   = '0;
      end else begin
        state_d = IDLE;
        ptr_d   = ptr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      ptr_q   <= start_addr;
      end_q   <= '0;
      k_q     <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      term_q  <= 1'b0;
      first_q <= 1'b1;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      k_q     <= k_d;
      word_q  <= word_d;
      last_q  <= last_d;
      term_q  <= term_d;
      first_q <= first_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      full_q  <= full_d;
      error_q <= error_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign sram_cs   = cs_q;
  assign sram_we   = we_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign done      = done_q;
  assign full      = full_q;
  assign error     = error_q;

endmodule

// File: tb/tb_vocab_writer.sv
// Directed scoreboard bench for vocab_writer: expected SRAM writes are queued as stimulus
// is driven and checked by a bus monitor; flags and timing are checked inline.
module tb_vocab_writer;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [3:0]  start_addr;
  logic [3:0]  end_addr;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_word;
  logic        in_last;
  logic        sram_cs;
  logic        sram_we;
  logic [3:0]  sram_addr;
  logic [7:0]  sram_din;
  logic [7:0]  sram_dout;
  logic        busy;
  logic        done;
  logic        full;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  logic [7:0] mem [16];
  bit         corrupt_en = 1'b0;

  vocab_writer #(
    .ADDR_WIDTH (4),
    .WORD_LENGTH(3),
    .DATA_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .start_addr(start_addr),
    .end_addr  (end_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_last   (in_last),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model; address 1 can be made to read back inverted
  always @(posedge clk) begin
    if (sram_cs && sram_we) mem[sram_addr] <= sram_din;
    if (sram_cs && !sram_we)
      sram_dout <= (corrupt_en && sram_addr == 4'd1) ? (mem[sram_addr] ^ 8'hFF) : mem[sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sram_cs === 1'b1 && sram_we === 1'b1) begin
      check("wr_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", sram_addr, e.a);
        check("wr_data", sram_din, e.d);
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic do_reset(input logic [3:0] s, input logic [3:0] e);
    start_addr = s;
    end_addr   = e;
    in_valid   = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns #1 after the handshake edge.
  task automatic send(input logic [23:0] w, input logic l);
    int n = 0;
    in_word  = w;
    in_last  = l;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("hs_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_reached", done, 1);
  endtask

  initial begin
    int gap;
    int lat;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_word = '0; in_last = 1'b0;
    start_addr = '0; end_addr = 4'd15;

    // Reset state
    do_reset(4'd0, 4'd15);
    check("rst_ready", in_ready, 1);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_full",  full, 0);
    check("rst_error", error, 0);
    check("rst_cs",    sram_cs, 0);
    check("rst_we",    sram_we, 0);
    check("rst_addr",  sram_addr, 0);
    check("rst_din",   sram_din, 0);

`ifndef VOCAB_WRITER_READBACK_EN
    // Single word plus terminator, done on the fifth cycle
    push(4'd0, 8'h61); push(4'd1, 8'h62); push(4'd2, 8'h63); push(4'd3, 8'h00);
    send(24'h636261, 1'b1);
    check("t1_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    check("t1_done_early", done, 0);
    @(posedge clk); #1;
    check("t1_done",  done, 1);
    check("t1_full",  full, 0);
    check("t1_busy_end", busy, 0);
    check("t1_ready_end", in_ready, 0);
    check("t1_cs_idle", sram_cs, 0);
    check("t1_addr_hold", sram_addr, 3);
    check("t1_error", error, 0);
    check("t1_drain", exp_q.size(), 0);

    // Back-to-back words with in_valid held high
    do_reset(4'd0, 4'd15);
    push(4'd0, 8'h63); push(4'd1, 8'h62); push(4'd2, 8'h61);
    push(4'd3, 8'h66); push(4'd4, 8'h65); push(4'd5, 8'h64); push(4'd6, 8'h00);
    in_word = 24'h616263; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_word = 24'h646566; in_last = 1'b1;
    gap = 0;
    while (in_ready !== 1'b1 && gap < 20) begin
      gap++;
      @(posedge clk); #1;
    end
    check("t2_ready_gap", gap, 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(20);
    check("t2_full", full, 0);
    check("t2_drain", exp_q.size(), 0);

    // Address space runs out mid-word
    do_reset(4'd0, 4'd4);
    push(4'd0, 8'h61); push(4'd1, 8'h62); push(4'd2, 8'h63);
    push(4'd3, 8'h64); push(4'd4, 8'h65);
    send(24'h636261, 1'b0);
    send(24'h666564, 1'b1);
    wait_done(20);
    check("t3_full", full, 1);
    check("t3_din_hold", sram_din, 8'h65);
    repeat (3) @(posedge clk);
    #1;
    check("t3_drain", exp_q.size(), 0);

    // clear on the second byte aborts the word and restarts from start_addr
    do_reset(4'd0, 4'd15);
    push(4'd0, 8'h61); push(4'd1, 8'h62);
    send(24'h636261, 1'b1);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t4_ready", in_ready, 1);
    check("t4_done",  done, 0);
    check("t4_busy",  busy, 0);
    check("t4_cs",    sram_cs, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_drain_abort", exp_q.size(), 0);
    push(4'd0, 8'h78); push(4'd1, 8'h79); push(4'd2, 8'h7a); push(4'd3, 8'h00);
    send(24'h7a7978, 1'b1);
    wait_done(20);
    check("t4_drain", exp_q.size(), 0);

    // Word fills the top of a window exactly; terminator dropped
    do_reset(4'd10, 4'd12);
    push(4'd10, 8'h61); push(4'd11, 8'h62); push(4'd12, 8'h63);
    send(24'h636261, 1'b1);
    wait_done(20);
    check("t5_full", full, 1);
    repeat (2) @(posedge clk);
    #1;
    check("t5_drain", exp_q.size(), 0);

    // end below start: full at once, nothing written
    do_reset(4'd5, 4'd3);
    send(24'h636261, 1'b1);
    check("t7_done", done, 1);
    check("t7_full", full, 1);
    check("t7_cs",   sram_cs, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t7_drain", exp_q.size(), 0);
`else
    // Readback with a corrupted location
    corrupt_en = 1'b1;
    push(4'd0, 8'h61); push(4'd1, 8'h62); push(4'd2, 8'h63); push(4'd3, 8'h00);
    send(24'h636261, 1'b1);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("t6_latency", lat, 12);
    check("t6_done",  done, 1);
    check("t6_error", error, 1);
    check("t6_full",  full, 0);
    check("t6_drain", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
